fta_io_slave32: RTL and testbench

FTA_IO_SLAVE32 -- requirements
Module: fta_io_slave32

---
 rtl/fta_bus_pkg.sv | 28 ++
 rtl/fta_addr_decode.sv | 12 +
 rtl/fta_io_slave32.sv | 127 ++++++++++++
 tb/tb_fta_io_slave32.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fta_bus_pkg.sv
// fta_bus_pkg: 32-bit bridge command request/response channel types.
package fta_bus_pkg;

   typedef struct packed {
      logic [3:0]  cid;
      logic [7:0]  tid;
      logic        cyc;
      logic        stb;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] padr;
      logic [31:0] dat;
   } fta_cmd_request32_t;

   typedef struct packed {
      logic [3:0]  cid;
      logic [7:0]  tid;
      logic        stall;
      logic        next;
      logic        ack;
      logic        rty;
      logic        err;
      logic [3:0]  pri;
      logic [31:0] adr;
      logic [31:0] dat;
   } fta_cmd_response32_t;

endpackage

// File: rtl/fta_addr_decode.sv
// fta_addr_decode: masked base-address window compare shared by bridge slaves.
module fta_addr_decode #(
   parameter logic [31:0] BASE = 32'hFEE00000,
   parameter logic [31:0] MASK = 32'hFFFF0000
) (
   input  logic [31:0] padr,
   output logic        hit
);

   assign hit = (padr & MASK) == BASE;

endmodule

// File: rtl/fta_io_slave32.sv
// fta_io_slave32: bridge-bus to simple device-port slave (IDLE/ACCESS/RESP) with one-deep retry buffer.
// Optional ACCESS timeout reported as resp.err when IO_SLAVE_TIMEOUT_EN is defined.
module fta_io_slave32
   import fta_bus_pkg::*;
#(
   parameter logic [31:0] BASE    = 32'hFEE00000,
   parameter logic [31:0] MASK    = 32'hFFFF0000,
   parameter int          TIMEOUT = 16,
   parameter logic [3:0]  PRI     = 4'd5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  fta_cmd_request32_t  req,
   output fta_cmd_response32_t resp,
   output logic                dev_cs_o,
   output logic                dev_we_o,
   output logic [3:0]          dev_sel_o,
   output logic [31:0]         dev_adr_o,
   output logic [31:0]         dev_dat_o,
   input  logic [31:0]         dev_dat_i,
   input  logic                dev_ack_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   fta_cmd_response32_t resp_d;
   logic [3:0]          cid_q, rty_cid_q;
   logic [7:0]          tid_q, rty_tid_q;
   logic [31:0]         rdat_q;
   logic                err_q, rty_pend_q;
   logic                win_hit, hit, tmo;

   fta_addr_decode #(.BASE(BASE), .MASK(MASK)) u_dec (.padr(req.padr), .hit(win_hit));

   assign hit = req.cyc & req.stb & win_hit;

`ifdef IO_SLAVE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;
   logic [CW-1:0] cnt_q;
   assign tmo = cnt_q == CW'(TIMEOUT - 1);
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d = (state_q == IDLE)   ? (hit ? ACCESS : IDLE)
              : (state_q == ACCESS) ? ((dev_ack_i || tmo) ? RESP : ACCESS)
              : IDLE;
      resp_d = '0;
      resp_d.stall = state_d != IDLE;
      // The completion always takes the slot; a retry colliding with it waits in rty_*_q.
      if (state_q == RESP) begin
         resp_d.cid = cid_q;
         resp_d.tid = tid_q;
         resp_d.adr = dev_adr_o;
         resp_d.dat = rdat_q;
         resp_d.pri = PRI;
         resp_d.ack = ~err_q;
         resp_d.err = err_q;
      end else if (rty_pend_q) begin
         resp_d.cid = rty_cid_q;
         resp_d.tid = rty_tid_q;
         resp_d.rty = 1'b1;
      end else if (hit && state_q != IDLE) begin
         resp_d.cid = req.cid;
         resp_d.tid = req.tid;
         resp_d.rty = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         resp       <= '0;
         dev_cs_o   <= 1'b0;
         dev_we_o   <= 1'b0;
         dev_sel_o  <= '0;
         dev_adr_o  <= '0;
         dev_dat_o  <= '0;
         cid_q      <= '0;
         tid_q      <= '0;
         rdat_q     <= '0;
         err_q      <= 1'b0;
         rty_pend_q <= 1'b0;
         rty_cid_q  <= '0;
         rty_tid_q  <= '0;
`ifdef IO_SLAVE_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q  <= state_d;
         resp     <= resp_d;
         dev_cs_o <= state_d == ACCESS;
         // Device-side registers double as the latched request.
         if (state_q == IDLE && hit) begin
            dev_we_o  <= req.we;
            dev_sel_o <= req.sel;
            dev_adr_o <= req.padr;
            dev_dat_o <= req.dat;
            cid_q     <= req.cid;
            tid_q     <= req.tid;
            err_q     <= 1'b0;
         end
         if (state_q == ACCESS && dev_ack_i)
            rdat_q <= dev_we_o ? '0 : dev_dat_i;
         else if (state_q == ACCESS && tmo) begin
            rdat_q <= '0;
            err_q  <= 1'b1;
         end
         rty_pend_q <= rty_pend_q ? (state_q == RESP) : (state_q == RESP && hit);
         if (!rty_pend_q && state_q == RESP && hit) begin
            rty_cid_q <= req.cid;
            rty_tid_q <= req.tid;
         end
`ifdef IO_SLAVE_TIMEOUT_EN
         cnt_q <= (state_q == ACCESS) ? cnt_q + CW'(1) : '0;
`endif
      end
   end

`ifndef SYNTHESIS
   a_rty_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(hit && state_q != IDLE && rty_pend_q));
`endif

endmodule

// File: tb/tb_fta_io_slave32.sv
// tb_fta_io_slave32: randomized scoreboard bench; a device model acks after a chosen delay.
module tb_fta_io_slave32;
   import fta_bus_pkg::*;

   localparam int          TMO = 16;
   localparam logic [31:0] WIN = 32'hFEE00000;

   logic                clk = 1'b0, rst;
   fta_cmd_request32_t  req;
   fta_cmd_response32_t resp;
   logic                dev_cs_o, dev_we_o, dev_ack_i;
   logic [3:0]          dev_sel_o;
   logic [31:0]         dev_adr_o, dev_dat_o, dev_dat_i;

   typedef struct {
      int unsigned         cyc;
      fta_cmd_response32_t r;
   } exp_t;

   exp_t        sbq[$];
   int unsigned cyc = 0;
   int          vecs = 0, errs = 0;
   bit          mon_en = 0;
   int          dev_delay = 1;
   logic [31:0] dev_rdata = '0, exp_adr = '0, exp_dat = '0;
   logic        exp_we = 1'b0;
   logic [3:0]  exp_sel = '0;

   fta_io_slave32 #(.BASE(32'hFEE00000), .MASK(32'hFFFF0000), .TIMEOUT(TMO), .PRI(4'd5)) dut (
      .clk_i(clk), .rst_i(rst), .req(req), .resp(resp),
      .dev_cs_o(dev_cs_o), .dev_we_o(dev_we_o), .dev_sel_o(dev_sel_o),
      .dev_adr_o(dev_adr_o), .dev_dat_o(dev_dat_o),
      .dev_dat_i(dev_dat_i), .dev_ack_i(dev_ack_i)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int unsigned c, input fta_cmd_response32_t r);
      exp_t e;
      int   i = 0;
      e.cyc = c;
      e.r   = r;
      while (i < sbq.size() && sbq[i].cyc <= c) i++;
      sbq.insert(i, e);
   endtask

   // Device model: acks in the d-th ACCESS cycle (d == 0 never acks).
   initial begin
      int n = 0;
      dev_ack_i = 1'b0;
      dev_dat_i = '0;
      forever begin
         @(negedge clk);
         if (dev_cs_o && !rst) begin
            n++;
            if (n == 1) begin
               check("dev_out", {dev_we_o, dev_sel_o, dev_adr_o, dev_dat_o}, {exp_we, exp_sel, exp_adr, exp_dat});
               check("stall_busy", 128'(resp.stall), 128'(1));
            end
            dev_ack_i = dev_delay != 0 && n == dev_delay;
            dev_dat_i = dev_ack_i ? dev_rdata : $urandom;
         end else begin
            n = 0;
            dev_ack_i = 1'b0;
            dev_dat_i = $urandom;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents ack/rty/err.
   initial begin
      fta_cmd_response32_t a;
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            a = resp;
            a.stall = 1'b0;
            if (resp.ack || resp.rty || resp.err) begin
               if (sbq.size() == 0) check("unexpected_resp", 128'(a), '0);
               else begin
                  e = sbq.pop_front();
                  e.r.stall = 1'b0;
                  check("resp", {cyc, a}, {e.cyc, e.r});
               end
            end else begin
               check("quiet_resp_zero", 128'(a), '0);
               if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                  e = sbq.pop_front();
                  check("missing_resp_cyc", 128'(cyc), 128'(e.cyc));
               end
            end
         end
      end
   end

   task automatic run(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] dat,
                      input logic [3:0] cid, input logic [7:0] tid, input int d, input logic [31:0] rd,
                      input int intr, input logic [3:0] cid2, input logic [7:0] tid2);
      fta_cmd_response32_t r;
      int          n;
      bit          to;
      int unsigned e0, ac, rc;
`ifdef IO_SLAVE_TIMEOUT_EN
      to = d == 0 || d > TMO;
`else
      to = 1'b0;
`endif
      n = to ? TMO : d;
      dev_delay = d;
      dev_rdata = rd;
      exp_we = we; exp_sel = sel; exp_adr = adr; exp_dat = dat;
      @(negedge clk);
      req = '0;
      req.cyc = 1'b1; req.stb = 1'b1; req.we = we; req.sel = sel;
      req.padr = adr; req.dat = dat; req.cid = cid; req.tid = tid;
      e0 = cyc;
      ac = e0 + n + 2;
      r = '0;
      r.cid = cid; r.tid = tid; r.adr = adr; r.pri = 4'd5;
      r.ack = !to; r.err = to;
      r.dat = (we || to) ? 32'h0 : rd;
      push(ac, r);
      @(negedge clk);
      req = '0;
      for (int j = 1; j <= n + 1; j++) begin
         if (j == intr) begin
            req.cyc = 1'b1; req.stb = 1'b1; req.we = 1'($urandom);
            req.padr = WIN | $urandom_range(0, 32'hFFFF);
            req.dat = $urandom; req.cid = cid2; req.tid = tid2;
            r = '0;
            r.cid = cid2; r.tid = tid2; r.rty = 1'b1;
            rc = e0 + 1 + j;
            if (rc == ac) rc++;
            push(rc, r);
         end
         @(negedge clk);
         req = '0;
      end
   endtask

   task automatic miss(input logic [31:0] adr, input logic stb);
      @(negedge clk);
      req = '0;
      req.cyc = 1'b1; req.stb = stb; req.padr = adr; req.tid = 8'($urandom);
      @(negedge clk);
      req = '0;
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      repeat (2) @(negedge clk);
      check("reset_state", {resp, dev_cs_o, dev_we_o, dev_sel_o, dev_adr_o, dev_dat_o}, '0);
      rst = 1'b0;
      mon_en = 1'b1;
      run(32'hFEE00010, 1'b0, 4'hF, 32'h0, 4'd3, 8'd7, 1, 32'hDEADBEEF, 0, 4'd0, 8'd0);
      run(32'hFEE00020, 1'b1, 4'hC, 32'h12345678, 4'd1, 8'd2, 2, 32'hCAFEF00D, 0, 4'd0, 8'd0);
      miss(32'hFED00000, 1'b1);
      repeat (4) begin
         @(negedge clk);
         check("miss_no_cs", 128'(dev_cs_o), '0);
      end
      run(32'hFEE00100, 1'b0, 4'h3, 32'h0, 4'd4, 8'd1, 3, 32'h01020304, 1, 4'd6, 8'd9);
      run(32'hFEE00200, 1'b0, 4'hF, 32'h0, 4'd5, 8'd2, 2, 32'hA5A55A5A, 3, 4'd7, 8'd11);
      for (int k = 0; k < 40; k++) begin
         int d = $urandom_range(1, 5);
         run(WIN | $urandom_range(0, 32'hFFFF), 1'($urandom), 4'($urandom), $urandom,
             4'($urandom), 8'($urandom), d, $urandom, $urandom_range(0, d + 1), 4'($urandom), 8'($urandom));
         case ($urandom_range(0, 3))
            0: miss(32'hFED00000 | $urandom_range(0, 32'hFFFF), 1'b1);
            1: miss(WIN | $urandom_range(0, 32'hFFFF), 1'b0);
            default: ;
         endcase
      end
      // Mid-ACCESS reset: the transaction must vanish without any response.
      dev_delay = 0;
      exp_we = 1'b0; exp_sel = 4'h5; exp_adr = 32'hFEE00300; exp_dat = 32'h0;
      @(negedge clk);
      req = '0;
      req.cyc = 1'b1; req.stb = 1'b1; req.sel = 4'h5; req.padr = 32'hFEE00300; req.tid = 8'd33;
      @(negedge clk);
      req = '0;
      repeat (2) @(negedge clk);
      check("pre_reset_cs", 128'(dev_cs_o), 128'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_reset_clear", {resp, dev_cs_o}, '0);
      repeat (3) begin
         @(negedge clk);
         check("post_reset_idle", {resp.stall, dev_cs_o}, '0);
      end
`ifdef IO_SLAVE_TIMEOUT_EN
      run(32'hFEE00400, 1'b0, 4'hF, 32'h0, 4'd2, 8'd40, 0, 32'h0, 0, 4'd0, 8'd0);
      run(32'hFEE00500, 1'b0, 4'hF, 32'h0, 4'd3, 8'd41, TMO, 32'h5555AAAA, 0, 4'd0, 8'd0);
      run(32'hFEE00600, 1'b1, 4'h1, 32'h77, 4'd4, 8'd42, 0, 32'h0, TMO + 1, 4'd9, 8'd43);
`endif
      for (int i = 0; i < 60 && sbq.size() > 0; i++) @(negedge clk);
      vecs++;
      if (sbq.size() != 0) begin
         errs++;
         $display("FAIL drain: %0d responses outstanding, want 0", sbq.size());
      end
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
